// File: rtl/sched_pkg.sv
// Shared types and constants for area_perim_sched: FSM state encoding, operand-set
// layout and accumulator width (accumulators exist only with AREA_PERIM_ACC_EN).
package sched_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        RESP = ST_RESP
    } state_e;

    typedef logic [15:0] ops_t;

    localparam int unsigned FIELD_W = 4;
    localparam int unsigned A_LSB   = 12;
    localparam int unsigned B_LSB   = 8;
    localparam int unsigned C_LSB   = 4;
    localparam int unsigned D_LSB   = 0;

    localparam int unsigned ACC_W = 8;
    typedef logic [ACC_W-1:0] acc_t;

    function automatic logic [FIELD_W-1:0] abs_diff(input logic [FIELD_W-1:0] x,
                                                     input logic [FIELD_W-1:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/area_perim_sched_ap.sv
// AreaPerim: combinational rectangle datapath; M = area mod 16, N = perimeter mod 16
// of the rectangle spanned by corners (A,B) and (C,D).
module AreaPerim
    import sched_pkg::*;
(
    input  ops_t       i_ops,
    output logic [3:0] M,
    output logic [3:0] N
);

    logic [FIELD_W-1:0] w_a, w_b, w_c, w_d;
    logic [FIELD_W-1:0] w_width, w_height, w_sum;

    assign w_a = i_ops[A_LSB +: FIELD_W];
    assign w_b = i_ops[B_LSB +: FIELD_W];
    assign w_c = i_ops[C_LSB +: FIELD_W];
    assign w_d = i_ops[D_LSB +: FIELD_W];

    assign w_width  = abs_diff(w_c, w_a);
    assign w_height = abs_diff(w_d, w_b);

    // 4-bit arithmetic gives the mod-16 wrap directly.
    assign M     = w_width * w_height;
    assign w_sum = w_width + w_height;
    assign N     = {w_sum[2:0], 1'b0};

endmodule

// File: rtl/area_perim_sched.sv
// Two-requester scheduler sharing one AreaPerim datapath (IDLE -> CALC -> RESP).
// Optional per-requester area accumulators with acc_clr: define AREA_PERIM_ACC_EN.
module area_perim_sched
    import sched_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r0_valid,
    input  ops_t       r0_ops,
    output logic       r0_ready,
    input  logic       r1_valid,
    input  ops_t       r1_ops,
    output logic       r1_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_tag,
    output logic [3:0] out_area,
    output logic [3:0] out_perim,
    output logic       busy
`ifdef AREA_PERIM_ACC_EN
    ,
    input  logic       acc_clr,
    output acc_t       acc0,
    output acc_t       acc1
`endif
);

    state_e     r_state;
    logic       r_last;
    ops_t       r_ops;
    logic       r_tag;
    logic [3:0] r_area;
    logic [3:0] r_perim;

    logic       w_idle;
    logic       w_pick1;
    logic       w_grant0;
    logic       w_grant1;
    logic [3:0] w_m;
    logic [3:0] w_n;

    // Readies are gated by rst so nothing is granted before the first edge after release.
    assign w_idle   = (r_state == IDLE) && !rst;
    assign w_pick1  = r1_valid && (!r0_valid || ((FIXED_PRIO == 0) && (r_last == 1'b0)));
    assign w_grant0 = w_idle && r0_valid && !w_pick1;
    assign w_grant1 = w_idle && w_pick1;

    assign r0_ready  = w_grant0;
    assign r1_ready  = w_grant1;
    assign out_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign out_tag   = r_tag;
    assign out_area  = r_area;
    assign out_perim = r_perim;

    AreaPerim u_ap (
        .i_ops (r_ops),
        .M     (w_m),
        .N     (w_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_ops   <= '0;
            r_tag   <= 1'b0;
            r_area  <= '0;
            r_perim <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_ops   <= w_pick1 ? r1_ops : r0_ops;
                        r_tag   <= w_pick1;
                        r_last  <= w_pick1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_area  <= w_m;
                    r_perim <= w_n;
                    r_state <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef AREA_PERIM_ACC_EN
    acc_t           r_acc0;
    acc_t           r_acc1;
    acc_t           w_sel;
    logic [ACC_W:0] w_sum;
    acc_t           w_sat;

    assign w_sel = r_tag ? r_acc1 : r_acc0;
    assign w_sum = {1'b0, w_sel} + (ACC_W + 1)'(r_area);
    assign w_sat = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc0 <= '0;
            r_acc1 <= '0;
        end else if (acc_clr) begin
            r_acc0 <= '0;
            r_acc1 <= '0;
        end else if (out_valid && out_ready) begin
            if (r_tag) begin
                r_acc1 <= w_sat;
            end else begin
                r_acc0 <= w_sat;
            end
        end
    end

    assign acc0 = r_acc0;
    assign acc1 = r_acc1;
`endif

endmodule

// File: tb/tb_area_perim_sched.sv
// Bench for area_perim_sched: round-robin and fixed-priority instances share stimulus
// and are checked every cycle against a transaction-level model; accumulators need AREA_PERIM_ACC_EN.
module tb_area_perim_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r1_valid, out_ready;
    logic [15:0] r0_ops, r1_ops;
    logic [1:0]  rdy0, rdy1, ov, otag, obusy;
    logic [3:0]  oarea [2];
    logic [3:0]  operim[2];
`ifdef AREA_PERIM_ACC_EN
    logic        acc_clr;
    logic [7:0]  oacc0[2];
    logic [7:0]  oacc1[2];
    int          m_acc[2][2];
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit m_pend[2];
    int m_due [2];
    bit m_last[2];
    int e_tag [2];
    int e_area[2];
    int e_perim[2];

    int hs_tag[$], hs_cyc[$], hs_area[$], hs_perim[$], acc_cyc[$];
    int r1_fixed_cnt = 0;
    int r1_acc_cnt   = 0;

    always #5 clk = ~clk;

    area_perim_sched #(.FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ops(r0_ops), .r0_ready(rdy0[0]),
        .r1_valid(r1_valid), .r1_ops(r1_ops), .r1_ready(rdy1[0]),
        .out_valid(ov[0]), .out_ready(out_ready), .out_tag(otag[0]),
        .out_area(oarea[0]), .out_perim(operim[0]), .busy(obusy[0])
`ifdef AREA_PERIM_ACC_EN
        , .acc_clr(acc_clr), .acc0(oacc0[0]), .acc1(oacc1[0])
`endif
    );

    area_perim_sched #(.FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ops(r0_ops), .r0_ready(rdy0[1]),
        .r1_valid(r1_valid), .r1_ops(r1_ops), .r1_ready(rdy1[1]),
        .out_valid(ov[1]), .out_ready(out_ready), .out_tag(otag[1]),
        .out_area(oarea[1]), .out_perim(operim[1]), .busy(obusy[1])
`ifdef AREA_PERIM_ACC_EN
        , .acc_clr(acc_clr), .acc0(oacc0[1]), .acc1(oacc1[1])
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int adiff(input int x, input int y);
        return (x > y) ? x - y : y - x;
    endfunction

    task automatic model_check(input int d);
        bit g0, g1, exp_ov, hs;
        int w, h;
        logic [15:0] ops;
        if (rst) begin
            chk("rst_r0_ready", 16'(rdy0[d]), 16'd0);
            chk("rst_r1_ready", 16'(rdy1[d]), 16'd0);
            chk("rst_out_valid", 16'(ov[d]), 16'd0);
            chk("rst_busy", 16'(obusy[d]), 16'd0);
            chk("rst_out_tag", 16'(otag[d]), 16'd0);
            chk("rst_out_area", 16'(oarea[d]), 16'd0);
            chk("rst_out_perim", 16'(operim[d]), 16'd0);
`ifdef AREA_PERIM_ACC_EN
            chk("rst_acc0", 16'(oacc0[d]), 16'd0);
            chk("rst_acc1", 16'(oacc1[d]), 16'd0);
            m_acc[d][0] = 0;
            m_acc[d][1] = 0;
`endif
            m_pend[d] = 1'b0;
            m_last[d] = 1'b1;
            return;
        end
        exp_ov = m_pend[d] && (cyc >= m_due[d]);
        chk("out_valid", 16'(ov[d]), 16'(exp_ov));
        chk("busy", 16'(obusy[d]), 16'(m_pend[d]));
        if (exp_ov) begin
            chk("out_tag", 16'(otag[d]), 16'(e_tag[d]));
            chk("out_area", 16'(oarea[d]), 16'(e_area[d]));
            chk("out_perim", 16'(operim[d]), 16'(e_perim[d]));
        end
        g0 = 1'b0;
        g1 = 1'b0;
        if (!m_pend[d]) begin
            if (r0_valid && r1_valid) begin
                if (d == 1 || m_last[d]) g0 = 1'b1;
                else                     g1 = 1'b1;
            end else begin
                g0 = r0_valid;
                g1 = r1_valid;
            end
        end
        chk("r0_ready", 16'(rdy0[d]), 16'(g0));
        chk("r1_ready", 16'(rdy1[d]), 16'(g1));
`ifdef AREA_PERIM_ACC_EN
        chk("acc0", 16'(oacc0[d]), 16'(m_acc[d][0]));
        chk("acc1", 16'(oacc1[d]), 16'(m_acc[d][1]));
`endif
        if (d == 0 && ov[0] && out_ready) begin
            hs_tag.push_back(int'(otag[0]));
            hs_cyc.push_back(cyc);
            hs_area.push_back(int'(oarea[0]));
            hs_perim.push_back(int'(operim[0]));
        end
        if (d == 0 && (rdy0[0] || rdy1[0])) acc_cyc.push_back(cyc);
        if (d == 0 && rdy1[0]) r1_acc_cnt++;
        if (d == 1 && rdy1[1]) r1_fixed_cnt++;
        hs = exp_ov && out_ready;
`ifdef AREA_PERIM_ACC_EN
        if (acc_clr) begin
            m_acc[d][0] = 0;
            m_acc[d][1] = 0;
        end else if (hs) begin
            m_acc[d][e_tag[d]] = (m_acc[d][e_tag[d]] + e_area[d] > 255) ? 255
                                 : m_acc[d][e_tag[d]] + e_area[d];
        end
`endif
        if (hs) m_pend[d] = 1'b0;
        if (g0 || g1) begin
            ops = g1 ? r1_ops : r0_ops;
            w = adiff(int'(ops[7:4]), int'(ops[15:12]));
            h = adiff(int'(ops[3:0]), int'(ops[11:8]));
            e_area[d]  = (w * h) % 16;
            e_perim[d] = (2 * w + 2 * h) % 16;
            e_tag[d]   = g1 ? 1 : 0;
            m_last[d]  = g1;
            m_pend[d]  = 1'b1;
            m_due[d]   = cyc + 2;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check(0);
        model_check(1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        hs_tag.delete(); hs_cyc.delete(); hs_area.delete(); hs_perim.delete(); acc_cyc.delete();
        r1_fixed_cnt = 0;
        r1_acc_cnt   = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        r0_valid = 1'b1; r1_valid = 1'b1; out_ready = 1'b1;
        r0_ops = 16'h1153; r1_ops = 16'h0FF0;
`ifdef AREA_PERIM_ACC_EN
        acc_clr = 1'b0;
`endif
        // Valids held high during reset: readies must stay low.
        tick(); tick(); tick();
        r0_valid = 1'b0; r1_valid = 1'b0;
        rst = 1'b0;
        tick();

        // r0 alone, 0x1153: area 8, perim 12, tag 0, valid at t+2.
        clear_logs();
        r0_valid = 1'b1; r0_ops = 16'h1153; out_ready = 1'b1;
        tick();
        r0_valid = 1'b0; r0_ops = 16'hFFFF;
        for (int i = 0; i < 4; i++) tick();
        chk("single_hs_count", 16'(hs_tag.size()), 16'd1);
        chk("single_acc_count", 16'(acc_cyc.size()), 16'd1);
        if (hs_tag.size() == 1 && acc_cyc.size() == 1) begin
            chk("single_tag", 16'(hs_tag[0]), 16'd0);
            chk("single_area", 16'(hs_area[0]), 16'd8);
            chk("single_perim", 16'(hs_perim[0]), 16'd12);
            chk("single_latency", 16'(hs_cyc[0] - acc_cyc[0]), 16'd2);
        end

        // Both valid continuously from reset: RR alternates 0,1,0,1; fixed never grants r1.
        do_reset();
        clear_logs();
        r0_valid = 1'b1; r1_valid = 1'b1; r0_ops = 16'h2468; r1_ops = 16'h9137;
        for (int i = 0; i < 15; i++) tick();
        r0_valid = 1'b0; r1_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("rr_enough_results", 16'(hs_tag.size() >= 4), 16'd1);
        if (hs_tag.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_tag_seq", 16'(hs_tag[i]), 16'(i % 2));
            for (int i = 1; i < 4; i++) chk("rr_spacing", 16'(hs_cyc[i] - hs_cyc[i-1]), 16'd3);
        end
        chk("fixed_r1_ready_count", 16'(r1_fixed_cnt), 16'd0);

        // r1 0x0FF0 with a 5-cycle stall in RESP; r1 keeps requesting.
        clear_logs();
        r1_valid = 1'b1; r1_ops = 16'h0FF0; out_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("stall_valid_held", 16'(ov[0]), 16'd1);
        chk("stall_no_new_grant", 16'(acc_cyc.size()), 16'd1);
        out_ready = 1'b1;
        tick();
        r1_valid = 1'b0;
        tick();
        chk("stall_hs_count", 16'(hs_tag.size()), 16'd1);
        if (hs_tag.size() == 1) begin
            chk("stall_tag", 16'(hs_tag[0]), 16'd1);
            chk("stall_area", 16'(hs_area[0]), 16'd1);
            chk("stall_perim", 16'(hs_perim[0]), 16'd12);
        end

        // Reset pulsed during CALC: outputs clear at once, nothing replayed afterwards.
        clear_logs();
        r0_valid = 1'b1; r0_ops = 16'h0F0F;
        tick();
        r0_valid = 1'b0;
        chk("pre_rst_busy", 16'(obusy[0]), 16'd1);
        rst = 1'b1;
        #1;
        chk("rst_now_busy", 16'(obusy[0]), 16'd0);
        chk("rst_now_valid", 16'(ov[0]), 16'd0);
        chk("rst_now_area", 16'(oarea[0]), 16'd0);
        chk("rst_now_perim", 16'(operim[0]), 16'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_no_stale", 16'(hs_tag.size()), 16'd0);

`ifdef AREA_PERIM_ACC_EN
        // 20 requests of area 15 from r1 saturate acc1; acc_clr clears it.
        do_reset();
        clear_logs();
        r1_valid = 1'b1; r1_ops = 16'h0053; out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (r1_acc_cnt >= 20) r1_valid = 1'b0;
            if (r1_acc_cnt >= 20 && hs_tag.size() >= 20) break;
        end
        r1_valid = 1'b0;
        chk("acc_hs_count", 16'(hs_tag.size()), 16'd20);
        chk("acc1_saturated", 16'(oacc1[0]), 16'd255);
        chk("acc0_zero", 16'(oacc0[0]), 16'd0);
        chk("acc1_saturated_fp", 16'(oacc1[1]), 16'd255);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        tick();
        chk("acc1_cleared", 16'(oacc1[0]), 16'd0);
`endif

        // Randomized traffic with stalls, occasional resets and changing operands.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r0_valid  = ($urandom_range(3) != 0);
            r1_valid  = ($urandom_range(3) != 0);
            r0_ops    = 16'($urandom);
            r1_ops    = 16'($urandom);
            out_ready = ($urandom_range(9) < 7);
            rst       = ($urandom_range(63) == 0);
`ifdef AREA_PERIM_ACC_EN
            acc_clr   = ($urandom_range(49) == 0);
`endif
            tick();
        end
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/area_perim_sched.md
AREA_PERIM_SCHED -- requirements
Module: area_perim_sched

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration; 1 means requester 0 always wins.
REQ-002 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Ports r0_valid / r1_valid, input, 1 each: requester has an operand set.
REQ-005 Ports r0_ops / r1_ops, input, 16 each: operand packing {A[15:12], B[11:8], C[7:4], D[3:0]}, 4-bit unsigned each.
REQ-006 Ports r0_ready / r1_ready, output, 1 each: request accepted this cycle.
REQ-007 Port out_valid, output, 1: result available.
REQ-008 Port out_ready, input, 1: consumer takes result.
REQ-009 Port out_tag, output, 1: requester index that owns the result.
REQ-010 Port out_area, output, 4: area result.
REQ-011 Port out_perim, output, 4: perimeter result.
REQ-012 Port busy, output, 1: FSM not in IDLE.

Function
REQ-013 FSM states SHALL be IDLE, CALC and RESP only.
REQ-014 In IDLE with any valid request, the FSM SHALL grant one requester, assert only that requester's ready for that cycle, latch its ops and the tag, and go to CALC.
REQ-015 In IDLE with no valid request, the FSM SHALL stay in IDLE with both readies low.
REQ-016 Readies SHALL be low in CALC and RESP, and a ready SHALL never depend on that requester's own ready.
REQ-017 Round-robin (FIXED_PRIO=0): on simultaneous valids the grant SHALL go to the requester not granted last; the last-grant pointer SHALL reset to 1, so requester 0 wins first.
REQ-018 In CALC, the latched ops SHALL drive one shared AreaPerim instance, its M and N outputs SHALL be registered into out_area and out_perim, and the FSM SHALL go to RESP.
REQ-019 Arithmetic: width = |C-A|, height = |D-B|, area = (width*height) mod 16, perimeter = (2*width + 2*height) mod 16, with no saturation or overflow flag.
REQ-020 In RESP, out_valid SHALL be 1 and out_area, out_perim and out_tag SHALL be held stable until out_ready is sampled high, after which the FSM SHALL return to IDLE with out_valid low the next cycle.
REQ-021 Latency SHALL be: accept at cycle t gives out_valid at t+2, and the peak rate is one result per 3 cycles.
REQ-022 A requester dropping valid while not granted SHALL have no effect, and operands SHALL be sampled only on the accept cycle.

Reset
REQ-023 While rst is high, the state SHALL be IDLE and out_valid, out_area, out_perim, out_tag, r0_ready, r1_ready and busy SHALL all be 0.
REQ-024 rst asserted mid-CALC or mid-RESP SHALL discard the in-flight result and not replay it.
REQ-025 The first grant after reset release SHALL occur no earlier than the first clk edge with rst low.

Configuration
REQ-026 Macro AREA_PERIM_ACC_EN, when defined, SHALL add outputs acc0 and acc1 (8 bits each): per-requester running sums of out_area, updated on each RESP handshake, saturating at 255, and cleared by reset and by a new input acc_clr (1 bit, synchronous, wins over a same-cycle update).
REQ-027 Without AREA_PERIM_ACC_EN, the acc0, acc1 and acc_clr ports and all accumulator logic SHALL be absent, with all other behaviour identical.

Structure
REQ-028 Shared package sched_pkg SHALL hold the state enum (IDLE, CALC, RESP), the 16-bit operand-set typedef, the field bit-position constants, and the accumulator width (8).
REQ-029 The module SHALL instantiate exactly one AreaPerim sub-module as the shared datapath, and the arbiter SHALL be inline logic.

Verification
REQ-030 The bench SHALL cover: r0 alone, ops 0x1153 (A1 B1 C5 D3), out_ready=1 -> out_valid at t+2, area 8, perim 12, tag 0.
REQ-031 The bench SHALL cover: r0 and r1 both valid continuously, FIXED_PRIO=0 -> tags alternate 0,1,0,1, with results spaced exactly 3 cycles apart.
REQ-032 The bench SHALL cover: same stimulus with FIXED_PRIO=1 -> every tag 0, and r1_ready never asserted.
REQ-033 The bench SHALL cover: r1 ops 0x0FF0 (A0 BF CF D0), out_ready low for 5 cycles -> out_valid held with area 1 (225 mod 16), perim 12 (60 mod 16) stable, and no new grant.
REQ-034 The bench SHALL cover: rst pulsed during CALC -> all outputs 0 the same cycle and no stale result after release.
REQ-035 The bench SHALL cover, with AREA_PERIM_ACC_EN: 20 requests of area 15 from r1 -> acc1 saturates at 255, acc0 = 0, and acc_clr returns acc1 to 0.
